// File: rtl/async_fill_sequencer_if.sv
// Handshake bundle between the acquisition sequencer and its environment:
// trigger/enable inputs, FIFO backpressure, mux strobes and FIFO write port.
interface async_fill_sequencer_if;
  logic        fill_start;
  logic        fill_stop;
  logic        trigger;
  logic        dat_valid;
  logic        fifo_almost_full;
  logic [10:0] async_num_bursts;

  logic        select_fill_hdr;
  logic        select_waveform_hdr;
  logic        select_dat;
  logic        select_checksum;
  logic        checksum_init;
  logic        checksum_update;
  logic [22:0] current_waveform_num;
  logic [22:0] waveform_start_adr;
  logic [22:0] num_fill_bursts;
  logic        adc_acq_out_we;
  logic [22:0] adc_acq_out_adr;
  logic        trigger_lost;
  logic        overflow_err;
  logic        fill_done;
  logic        busy;

  // Sequencer side
  modport master (
    input  fill_start, fill_stop, trigger, dat_valid, fifo_almost_full,
           async_num_bursts,
    output select_fill_hdr, select_waveform_hdr, select_dat, select_checksum,
           checksum_init, checksum_update, current_waveform_num,
           waveform_start_adr, num_fill_bursts, adc_acq_out_we,
           adc_acq_out_adr, trigger_lost, overflow_err, fill_done, busy
  );

  // Environment side (trigger logic, mux, FIFO)
  modport slave (
    output fill_start, fill_stop, trigger, dat_valid, fifo_almost_full,
           async_num_bursts,
    input  select_fill_hdr, select_waveform_hdr, select_dat, select_checksum,
           checksum_init, checksum_update, current_waveform_num,
           waveform_start_adr, num_fill_bursts, adc_acq_out_we,
           adc_acq_out_adr, trigger_lost, overflow_err, fill_done, busy
  );
endinterface

// File: rtl/async_fill_sequencer.sv
// Async-mode acquisition sequencer for one ADC channel. Drives the
// header/data/checksum mux strobes and the DDR3 write FIFO port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no fill in progress
// ARMED    | fill open, waiting for a trigger or the end of the window
// WFM_HDR  | issuing a waveform header (stalls on FIFO backpressure)
// DATA     | issuing nb data bursts as dat_valid arrives (never stalls)
// FILL_HDR | issuing the fill header at burst address 0
// CHECKSUM | issuing the checksum word, then back to IDLE
module async_fill_sequencer (
  input  logic                    clk,
  input  logic                    reset,
  async_fill_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    WFM_HDR  = 3'd2,
    DATA     = 3'd3,
    FILL_HDR = 3'd4,
    CHECKSUM = 3'd5
  } state_t;

  localparam logic [22:0] WFM_NUM_MAX = 23'h7F_FFFF;

  state_t      r_state;
  logic [22:0] r_adr_cnt;
  logic [22:0] r_wfm_num;
  logic [22:0] r_wfm_start_adr;
  logic [22:0] r_num_fill_bursts;
  logic [22:0] r_out_adr;
  logic [10:0] r_burst_cnt;
  logic [10:0] r_nb;
  logic        r_stop_pend;
  logic        r_we;
  logic        r_trigger_lost;
  logic        r_overflow_err;
  logic        r_fill_done;

  logic        w_sel_wfm;
  logic        w_sel_dat;
  logic        w_sel_fh;
  logic        w_sel_ck;
  logic        w_any_sel;
  logic        w_cks_init;
  logic        w_last_burst;
  logic        w_wfm_sat;
  logic [22:0] w_adr_inc;
  logic [22:0] w_nfb_next;

  // Mux strobes: decode of registered state plus live inputs
  assign w_sel_wfm    = (r_state == WFM_HDR)  && !bus.fifo_almost_full;
  assign w_sel_dat    = (r_state == DATA)     && bus.dat_valid;
  assign w_sel_fh     = (r_state == FILL_HDR) && !bus.fifo_almost_full;
  assign w_sel_ck     = (r_state == CHECKSUM) && !bus.fifo_almost_full;
  assign w_any_sel    = w_sel_wfm | w_sel_dat | w_sel_fh | w_sel_ck;
  assign w_cks_init   = (r_state == IDLE) && bus.fill_start;

  assign w_adr_inc    = r_adr_cnt + 23'd1;
  // num_fill_bursts tracks adr_cnt+1; computed for the value adr_cnt moves to
  assign w_nfb_next   = r_adr_cnt + 23'd2;
  assign w_last_burst = (r_burst_cnt + 11'd1) == r_nb;
  assign w_wfm_sat    = (r_wfm_num == WFM_NUM_MAX);

  // Sequencer FSM, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= IDLE;
      r_adr_cnt         <= '0;
      r_wfm_num         <= '0;
      r_wfm_start_adr   <= '0;
      r_num_fill_bursts <= '0;
      r_out_adr         <= '0;
      r_burst_cnt       <= '0;
      r_nb              <= '0;
      r_stop_pend       <= 1'b0;
      r_we              <= 1'b0;
      r_trigger_lost    <= 1'b0;
      r_overflow_err    <= 1'b0;
      r_fill_done       <= 1'b0;
    end else begin
      r_trigger_lost <= 1'b0;
      r_fill_done    <= 1'b0;

      // The mux registers its output, so the FIFO write trails the select
      r_we <= w_any_sel;
      if (w_any_sel) begin
        r_out_adr <= w_sel_fh ? 23'd0 : r_adr_cnt;
      end

      case (r_state)
        IDLE: begin
          if (bus.fill_start) begin
            // address 0 stays free for the fill header
            r_adr_cnt         <= 23'd1;
            r_num_fill_bursts <= 23'd2;
            r_wfm_num         <= '0;
            r_stop_pend       <= 1'b0;
            r_nb              <= bus.async_num_bursts;
            r_state           <= ARMED;
          end
        end

        ARMED: begin
          if (bus.fill_stop || r_stop_pend) begin
            // end of window wins over a coincident trigger
            r_state <= FILL_HDR;
            if (bus.trigger) begin
              r_trigger_lost <= 1'b1;
            end
          end else if (bus.trigger) begin
            if (w_wfm_sat) begin
              r_trigger_lost <= 1'b1;
            end else begin
              r_wfm_start_adr <= r_adr_cnt;
              r_state         <= WFM_HDR;
            end
          end
        end

        WFM_HDR: begin
          if (bus.trigger) begin
            r_trigger_lost <= 1'b1;
          end
          if (bus.fill_stop) begin
            r_stop_pend <= 1'b1;
          end
          if (w_sel_wfm) begin
            // mux samples the pre-increment index on this edge
            r_adr_cnt         <= w_adr_inc;
            r_num_fill_bursts <= w_nfb_next;
            r_wfm_num         <= r_wfm_num + 23'd1;
            r_burst_cnt       <= '0;
            r_state           <= (r_nb == 11'd0) ? ARMED : DATA;
          end
        end

        DATA: begin
          if (bus.trigger) begin
            r_trigger_lost <= 1'b1;
          end
          if (bus.fill_stop) begin
            r_stop_pend <= 1'b1;
          end
          if (bus.dat_valid) begin
            // datapath cannot stall; a burst under backpressure is flagged
            if (bus.fifo_almost_full) begin
              r_overflow_err <= 1'b1;
            end
            r_adr_cnt         <= w_adr_inc;
            r_num_fill_bursts <= w_nfb_next;
            r_burst_cnt       <= r_burst_cnt + 11'd1;
            if (w_last_burst) begin
              r_state <= r_stop_pend ? FILL_HDR : ARMED;
            end
          end
        end

        FILL_HDR: begin
          if (bus.trigger) begin
            r_trigger_lost <= 1'b1;
          end
          if (w_sel_fh) begin
            r_state <= CHECKSUM;
          end
        end

        CHECKSUM: begin
          if (bus.trigger) begin
            r_trigger_lost <= 1'b1;
          end
          if (w_sel_ck) begin
            r_fill_done <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.select_waveform_hdr  = w_sel_wfm;
  assign bus.select_dat           = w_sel_dat;
  assign bus.select_fill_hdr      = w_sel_fh;
  assign bus.select_checksum      = w_sel_ck;
  assign bus.checksum_init        = w_cks_init;
  assign bus.checksum_update      = w_sel_dat;
  assign bus.current_waveform_num = r_wfm_num;
  assign bus.waveform_start_adr   = r_wfm_start_adr;
  assign bus.num_fill_bursts      = r_num_fill_bursts;
  assign bus.adc_acq_out_we       = r_we;
  assign bus.adc_acq_out_adr      = r_out_adr;
  assign bus.trigger_lost         = r_trigger_lost;
  assign bus.overflow_err         = r_overflow_err;
  assign bus.fill_done            = r_fill_done;
  assign bus.busy                 = (r_state != IDLE);

endmodule

// File: tb/tb_async_fill_sequencer.sv
// Directed bench for async_fill_sequencer: each task runs one scenario and
// checks mux selects, FIFO write addresses and status flags.
module tb_async_fill_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  async_fill_sequencer_if bus();

  async_fill_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  typ;   // 1 wfm hdr, 2 data, 3 fill hdr, 4 checksum
    logic [22:0] wnum;
    logic [22:0] nfb;
  } rec_t;

  rec_t        sel_q[$];
  logic [22:0] adr_q[$];
  int          n_done = 0;
  int          n_lost = 0;
  int          n_multi_sel = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  // Record every mux select and every FIFO write, mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      rec_t r;
      int   ns;
      ns = int'(bus.select_waveform_hdr) + int'(bus.select_dat) +
           int'(bus.select_fill_hdr) + int'(bus.select_checksum);
      if (ns > 1) n_multi_sel++;
      if (ns > 0) begin
        r.typ  = bus.select_waveform_hdr ? 3'd1 : bus.select_dat ? 3'd2 :
                 bus.select_fill_hdr ? 3'd3 : 3'd4;
        r.wnum = bus.current_waveform_num;
        r.nfb  = bus.num_fill_bursts;
        sel_q.push_back(r);
      end
      if (bus.adc_acq_out_we) adr_q.push_back(bus.adc_acq_out_adr);
      if (bus.fill_done) n_done++;
      if (bus.trigger_lost) n_lost++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fill_start = 0; bus.fill_stop = 0; bus.trigger = 0;
    bus.dat_valid = 0; bus.fifo_almost_full = 0; bus.async_num_bursts = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.adc_acq_out_we !== 1'b0) $display("FAIL rst_we got %0b exp 0", bus.adc_acq_out_we); else pass_cnt++;
    total_cnt++; if (bus.num_fill_bursts !== 23'd0) $display("FAIL rst_nfb got %0d exp 0", bus.num_fill_bursts); else pass_cnt++;
    total_cnt++; if (bus.current_waveform_num !== 23'd0) $display("FAIL rst_wnum got %0d exp 0", bus.current_waveform_num); else pass_cnt++;
    total_cnt++; if ({bus.select_fill_hdr, bus.select_waveform_hdr, bus.select_dat, bus.select_checksum,
                      bus.checksum_init, bus.checksum_update, bus.overflow_err, bus.fill_done, bus.trigger_lost} !== 9'd0)
                   $display("FAIL rst_flags got nonzero exp 0"); else pass_cnt++;
    tick();
    reset = 0;
    tick();
    bus.fill_start = 1; bus.async_num_bursts = 11'd2;
    #1;
    total_cnt++; if (bus.checksum_init !== 1'b1) $display("FAIL cks_init got %0b exp 1", bus.checksum_init); else pass_cnt++;
    bus.fill_start = 0;
    #1;
    total_cnt++; if (bus.checksum_init !== 1'b0) $display("FAIL cks_init_idle got %0b exp 0", bus.checksum_init); else pass_cnt++;
  endtask

  task automatic test_basic_fill();
    int et[5] = '{1, 2, 2, 3, 4};
    logic [22:0] ea[5] = '{23'd1, 23'd2, 23'd3, 23'd0, 23'd4};
    sel_q.delete(); adr_q.delete(); n_done = 0;
    bus.fill_start = 1; bus.async_num_bursts = 11'd2; tick();
    bus.fill_start = 0; bus.async_num_bursts = 11'd0;
    bus.trigger = 1; tick();
    bus.trigger = 0;
    total_cnt++; if (bus.waveform_start_adr !== 23'd1) $display("FAIL basic_wsa got %0d exp 1", bus.waveform_start_adr); else pass_cnt++;
    tick();
    bus.dat_valid = 1; tick(); tick();
    bus.dat_valid = 0; bus.fill_stop = 1; tick();
    bus.fill_stop = 0; tick(); tick();
    total_cnt++; if (bus.fill_done !== 1'b1) $display("FAIL basic_done got %0b exp 1", bus.fill_done); else pass_cnt++;
    tick();
    total_cnt++; if (bus.fill_done !== 1'b0) $display("FAIL basic_done_clr got %0b exp 0", bus.fill_done); else pass_cnt++;
    total_cnt++; if (sel_q.size() != 5 || adr_q.size() != 5) $display("FAIL basic_len got %0d/%0d exp 5", sel_q.size(), adr_q.size()); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (i < sel_q.size() && i < adr_q.size()) begin
        total_cnt++;
        if (int'(sel_q[i].typ) != et[i] || adr_q[i] !== ea[i])
          $display("FAIL basic_wr%0d got typ %0d adr %0d exp typ %0d adr %0d", i, sel_q[i].typ, adr_q[i], et[i], ea[i]);
        else pass_cnt++;
      end
    end
    if (sel_q.size() == 5) begin
      total_cnt++; if (sel_q[0].wnum !== 23'd0) $display("FAIL basic_hdr_idx got %0d exp 0", sel_q[0].wnum); else pass_cnt++;
      total_cnt++; if (sel_q[3].wnum !== 23'd1 || sel_q[3].nfb !== 23'd5)
                     $display("FAIL basic_fhdr got wnum %0d nfb %0d exp 1 5", sel_q[3].wnum, sel_q[3].nfb); else pass_cnt++;
    end
    total_cnt++; if (n_done != 1) $display("FAIL basic_done_cnt got %0d exp 1", n_done); else pass_cnt++;
  endtask

  task automatic test_multi_trigger();
    int et[5] = '{1, 1, 1, 3, 4};
    logic [22:0] ea[5] = '{23'd1, 23'd2, 23'd3, 23'd0, 23'd4};
    sel_q.delete(); adr_q.delete();
    bus.fill_start = 1; bus.async_num_bursts = 11'd0; tick();
    bus.fill_start = 0;
    for (int k = 0; k < 3; k++) begin
      bus.trigger = 1; tick();
      bus.trigger = 0; tick();
    end
    total_cnt++; if (bus.waveform_start_adr !== 23'd3) $display("FAIL multi_wsa got %0d exp 3", bus.waveform_start_adr); else pass_cnt++;
    bus.fill_stop = 1; tick();
    bus.fill_stop = 0; tick(); tick(); tick();
    total_cnt++; if (sel_q.size() != 5 || adr_q.size() != 5) $display("FAIL multi_len got %0d/%0d exp 5", sel_q.size(), adr_q.size()); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (i < sel_q.size() && i < adr_q.size()) begin
        total_cnt++;
        if (int'(sel_q[i].typ) != et[i] || adr_q[i] !== ea[i])
          $display("FAIL multi_wr%0d got typ %0d adr %0d exp typ %0d adr %0d", i, sel_q[i].typ, adr_q[i], et[i], ea[i]);
        else pass_cnt++;
      end
    end
    if (sel_q.size() == 5) begin
      for (int i = 0; i < 3; i++) begin
        total_cnt++; if (sel_q[i].wnum !== 23'(i)) $display("FAIL multi_idx%0d got %0d exp %0d", i, sel_q[i].wnum, i); else pass_cnt++;
      end
      total_cnt++; if (sel_q[3].wnum !== 23'd3 || sel_q[3].nfb !== 23'd5)
                     $display("FAIL multi_fhdr got wnum %0d nfb %0d exp 3 5", sel_q[3].wnum, sel_q[3].nfb); else pass_cnt++;
    end
  endtask

  task automatic test_trigger_in_data();
    int et[6] = '{1, 2, 2, 2, 3, 4};
    logic [22:0] ea[6] = '{23'd1, 23'd2, 23'd3, 23'd4, 23'd0, 23'd5};
    int lost0;
    sel_q.delete(); adr_q.delete(); lost0 = n_lost;
    bus.fill_start = 1; bus.async_num_bursts = 11'd3; tick();
    bus.fill_start = 0;
    bus.trigger = 1; tick();
    bus.trigger = 0; tick();
    bus.dat_valid = 1; tick();
    bus.dat_valid = 0; bus.trigger = 1; tick();
    total_cnt++; if (bus.trigger_lost !== 1'b1) $display("FAIL tdat_lost got %0b exp 1", bus.trigger_lost); else pass_cnt++;
    bus.trigger = 0; bus.fill_stop = 1; bus.dat_valid = 1; tick();
    bus.fill_stop = 0; tick();
    bus.dat_valid = 0;
    #1;
    total_cnt++; if (bus.select_fill_hdr !== 1'b1) $display("FAIL tdat_fhdr_now got %0b exp 1", bus.select_fill_hdr); else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++; if (n_lost - lost0 != 1) $display("FAIL tdat_lost_cnt got %0d exp 1", n_lost - lost0); else pass_cnt++;
    total_cnt++; if (sel_q.size() != 6 || adr_q.size() != 6) $display("FAIL tdat_len got %0d/%0d exp 6", sel_q.size(), adr_q.size()); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      if (i < sel_q.size() && i < adr_q.size()) begin
        total_cnt++;
        if (int'(sel_q[i].typ) != et[i] || adr_q[i] !== ea[i])
          $display("FAIL tdat_wr%0d got typ %0d adr %0d exp typ %0d adr %0d", i, sel_q[i].typ, adr_q[i], et[i], ea[i]);
        else pass_cnt++;
      end
    end
    if (sel_q.size() == 6) begin
      total_cnt++; if (sel_q[4].nfb !== 23'd6) $display("FAIL tdat_nfb got %0d exp 6", sel_q[4].nfb); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int et[4] = '{1, 2, 3, 4};
    logic [22:0] ea[4] = '{23'd1, 23'd2, 23'd0, 23'd3};
    sel_q.delete(); adr_q.delete();
    bus.fill_start = 1; bus.async_num_bursts = 11'd1; tick();
    bus.fill_start = 0;
    bus.trigger = 1; tick();
    bus.trigger = 0; bus.fifo_almost_full = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total_cnt++; if (bus.select_waveform_hdr !== 1'b0) $display("FAIL bp_hold%0d got %0b exp 0", k, bus.select_waveform_hdr); else pass_cnt++;
      tick();
    end
    bus.fifo_almost_full = 0;
    #1;
    total_cnt++; if (bus.select_waveform_hdr !== 1'b1) $display("FAIL bp_release got %0b exp 1", bus.select_waveform_hdr); else pass_cnt++;
    tick();
    bus.fifo_almost_full = 1; bus.dat_valid = 1;
    #1;
    total_cnt++; if (bus.select_dat !== 1'b1 || bus.checksum_update !== 1'b1)
                   $display("FAIL bp_dat got sel %0b upd %0b exp 1 1", bus.select_dat, bus.checksum_update); else pass_cnt++;
    tick();
    bus.fifo_almost_full = 0; bus.dat_valid = 0;
    total_cnt++; if (bus.overflow_err !== 1'b1) $display("FAIL bp_ovf got %0b exp 1", bus.overflow_err); else pass_cnt++;
    bus.fill_stop = 1; tick();
    bus.fill_stop = 0; tick(); tick(); tick();
    total_cnt++; if (bus.overflow_err !== 1'b1) $display("FAIL bp_ovf_sticky got %0b exp 1", bus.overflow_err); else pass_cnt++;
    total_cnt++; if (sel_q.size() != 4 || adr_q.size() != 4) $display("FAIL bp_len got %0d/%0d exp 4", sel_q.size(), adr_q.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (i < sel_q.size() && i < adr_q.size()) begin
        total_cnt++;
        if (int'(sel_q[i].typ) != et[i] || adr_q[i] !== ea[i])
          $display("FAIL bp_wr%0d got typ %0d adr %0d exp typ %0d adr %0d", i, sel_q[i].typ, adr_q[i], et[i], ea[i]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_simul_stop_trigger();
    sel_q.delete(); adr_q.delete();
    bus.fill_start = 1; bus.async_num_bursts = 11'd1; tick();
    bus.fill_start = 0;
    bus.trigger = 1; bus.fill_stop = 1; tick();
    bus.trigger = 0; bus.fill_stop = 0;
    total_cnt++; if (bus.trigger_lost !== 1'b1) $display("FAIL simul_lost got %0b exp 1", bus.trigger_lost); else pass_cnt++;
    #1;
    total_cnt++; if (bus.select_fill_hdr !== 1'b1) $display("FAIL simul_fhdr got %0b exp 1", bus.select_fill_hdr); else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++; if (sel_q.size() != 2 || adr_q.size() != 2) $display("FAIL simul_len got %0d/%0d exp 2", sel_q.size(), adr_q.size()); else pass_cnt++;
    if (sel_q.size() == 2 && adr_q.size() == 2) begin
      total_cnt++;
      if (sel_q[0].typ !== 3'd3 || sel_q[0].wnum !== 23'd0 || sel_q[0].nfb !== 23'd2 || adr_q[0] !== 23'd0 ||
          sel_q[1].typ !== 3'd4 || adr_q[1] !== 23'd1)
        $display("FAIL simul_wr got typ %0d wnum %0d nfb %0d adr %0d / typ %0d adr %0d exp 3 0 2 0 / 4 1",
                 sel_q[0].typ, sel_q[0].wnum, sel_q[0].nfb, adr_q[0], sel_q[1].typ, adr_q[1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_data();
    int done0;
    int et[3] = '{1, 3, 4};
    logic [22:0] ea[3] = '{23'd1, 23'd0, 23'd2};
    bus.fill_start = 1; bus.async_num_bursts = 11'd4; tick();
    bus.fill_start = 0;
    bus.trigger = 1; tick();
    bus.trigger = 0; tick();
    bus.dat_valid = 1; tick(); tick();
    done0 = n_done;
    #1;
    reset = 1;
    #1;
    total_cnt++; if (bus.select_dat !== 1'b0 || bus.checksum_update !== 1'b0)
                   $display("FAIL rmid_sel got %0b %0b exp 0 0", bus.select_dat, bus.checksum_update); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rmid_busy got %0b exp 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.overflow_err !== 1'b0) $display("FAIL rmid_ovf got %0b exp 0", bus.overflow_err); else pass_cnt++;
    total_cnt++; if (bus.adc_acq_out_we !== 1'b0 || bus.adc_acq_out_adr !== 23'd0)
                   $display("FAIL rmid_wr got we %0b adr %0d exp 0 0", bus.adc_acq_out_we, bus.adc_acq_out_adr); else pass_cnt++;
    total_cnt++; if (bus.current_waveform_num !== 23'd0 || bus.waveform_start_adr !== 23'd0 || bus.num_fill_bursts !== 23'd0)
                   $display("FAIL rmid_cnt got %0d %0d %0d exp 0 0 0", bus.current_waveform_num, bus.waveform_start_adr, bus.num_fill_bursts); else pass_cnt++;
    bus.dat_valid = 0;
    tick(); tick();
    reset = 0;
    tick(); tick(); tick();
    total_cnt++; if (n_done != done0) $display("FAIL rmid_nodone got %0d exp %0d", n_done, done0); else pass_cnt++;
    sel_q.delete(); adr_q.delete();
    bus.fill_start = 1; bus.async_num_bursts = 11'd0; tick();
    bus.fill_start = 0;
    bus.trigger = 1; tick();
    bus.trigger = 0; tick();
    bus.fill_stop = 1; tick();
    bus.fill_stop = 0; tick(); tick(); tick();
    total_cnt++; if (sel_q.size() != 3 || adr_q.size() != 3) $display("FAIL rmid_len got %0d/%0d exp 3", sel_q.size(), adr_q.size()); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (i < sel_q.size() && i < adr_q.size()) begin
        total_cnt++;
        if (int'(sel_q[i].typ) != et[i] || adr_q[i] !== ea[i])
          $display("FAIL rmid_wr%0d got typ %0d adr %0d exp typ %0d adr %0d", i, sel_q[i].typ, adr_q[i], et[i], ea[i]);
        else pass_cnt++;
      end
    end
    if (sel_q.size() == 3) begin
      total_cnt++; if (sel_q[0].wnum !== 23'd0) $display("FAIL rmid_idx got %0d exp 0", sel_q[0].wnum); else pass_cnt++;
      total_cnt++; if (sel_q[1].nfb !== 23'd3) $display("FAIL rmid_nfb got %0d exp 3", sel_q[1].nfb); else pass_cnt++;
    end
    total_cnt++; if (n_multi_sel != 0) $display("FAIL onehot_sel got %0d cycles exp 0", n_multi_sel); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_multi_trigger();
    test_trigger_in_data();
    test_backpressure();
    test_simul_stop_trigger();
    test_reset_mid_data();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/async_fill_sequencer.md
# async_fill_sequencer

Sequences the async-mode ADC acquisition datapath for one channel. It drives the select, checksum-init and checksum-update strobes of the header/data/checksum mux, and supplies the mux with waveform index, waveform start address and total burst count. It also emits a write strobe and burst address for the DDR3 write FIFO. It sits between the trigger/acquisition-enable logic and the mux.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- fill_start  in  1  one-cycle pulse; begin a fill (honoured only in IDLE)
- fill_stop  in  1  one-cycle pulse; end of fill window
- trigger  in  1  one-cycle async trigger pulse
- dat_valid  in  1  a new 8-sample burst is present on the mux data inputs this cycle
- fifo_almost_full  in  1  DDR3 write FIFO backpressure
- async_num_bursts  in  11  data bursts per waveform; latched at fill_start
- select_fill_hdr, select_waveform_hdr, select_dat, select_checksum  out  1 each  mux selects, at most one high per cycle
- checksum_init, checksum_update  out  1 each  mux checksum controls
- current_waveform_num  out  23  waveform index; final count while the fill header is selected
- waveform_start_adr  out  23  burst address of the current waveform header
- num_fill_bursts  out  23  equals adr_cnt+1
- adc_acq_out_we  out  1  FIFO write strobe, aligned with registered mux output
- adc_acq_out_adr  out  23  burst address for the word being written
- trigger_lost  out  1  one-cycle pulse when a trigger is ignored
- overflow_err  out  1  sticky; set by a data burst accepted while fifo_almost_full
- fill_done  out  1  one-cycle pulse after the checksum is issued
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ARMED, WFM_HDR, DATA, FILL_HDR, CHECKSUM.
- Internal counters:
  - adr_cnt (23b): next free burst address.
  - burst_cnt (11b): data bursts issued in the current waveform.
  - stop_pend: latched fill_stop.
  - nb: latched async_num_bursts.
- IDLE + fill_start:
  - checksum_init=1 (combinational, same cycle).
  - adr_cnt<=1, because address 0 is reserved for the fill header.
  - current_waveform_num<=0, stop_pend<=0, nb<=async_num_bursts.
  - Next state ARMED.
- ARMED:
  - fill_stop or stop_pend -> FILL_HDR. fill_stop has priority over a simultaneous trigger; that trigger is ignored and trigger_lost pulses.
  - Otherwise trigger -> WFM_HDR with waveform_start_adr<=adr_cnt.
  - If current_waveform_num==23'h7FFFFF, triggers are ignored and trigger_lost pulses.
- WFM_HDR:
  - select_waveform_hdr = !fifo_almost_full. The state holds while the FIFO is almost full.
  - On a select cycle: adr_cnt+=1, current_waveform_num+=1 (mux samples the old value on this edge), burst_cnt<=0.
  - Next state DATA, or ARMED if nb==0.
- DATA:
  - select_dat = checksum_update = dat_valid. The datapath cannot stall: if fifo_almost_full && dat_valid, the burst is still issued and overflow_err is set.
  - Each accepted burst: adr_cnt+=1, burst_cnt+=1.
  - After the nb-th burst: go to ARMED, or directly to FILL_HDR if stop_pend.
- WFM_HDR/DATA: trigger -> trigger_lost pulse. fill_stop -> stop_pend<=1.
- FILL_HDR:
  - select_fill_hdr = !fifo_almost_full, written at address 0.
  - num_fill_bursts = adr_cnt+1, which counts the fill header, all waveforms and the checksum.
  - Next state CHECKSUM.
- CHECKSUM:
  - select_checksum = !fifo_almost_full, written at address adr_cnt.
  - On the select cycle, fill_done pulses on the next cycle and the state returns to IDLE.
- fill_start outside IDLE is ignored.
- Arithmetic is unsigned and modulo 2^23. No wrap occurs below the waveform-count saturation, which the system guarantees.

## Timing
- selects and checksum strobes: combinational decode of registered state plus inputs.
- adc_acq_out_we / adc_acq_out_adr: registered one cycle after any select (or of selects), matching the mux's one-cycle register. Address is 0 for the fill header; otherwise the adr_cnt value at the select cycle.
- trigger -> select_waveform_hdr: 1 cycle, if not backpressured.
- Minimum waveform length: 1+nb select cycles.
- Reset (any time, including mid-fill):
  - State IDLE; all counters and registered outputs 0; overflow_err 0.
  - Combinational outputs are 0 in IDLE without fill_start.
  - No fill_done is generated for an aborted fill.

## Test plan
- fill_start, nb=2, trigger, 2 dat_valid, fill_stop:
  - FIFO writes: wfm hdr @1 (index 0), data @2, @3, fill hdr @0 (count 1, num_fill_bursts 5), checksum @4.
  - fill_done one cycle after the checksum.
- Three triggers with nb=0:
  - Waveform headers at addresses 1, 2, 3 with indices 0, 1, 2.
  - Fill header shows 3 waveforms and num_fill_bursts=5.
- Trigger during DATA:
  - trigger_lost pulses, no extra header.
  - fill_stop during DATA -> FILL_HDR immediately after the last burst.
- fifo_almost_full held 5 cycles in WFM_HDR:
  - select_waveform_hdr stays low 5 cycles, then asserts once.
  - dat_valid while almost full in DATA -> burst written, overflow_err=1 until reset.
- Simultaneous trigger and fill_stop in ARMED: no waveform header, trigger_lost=1, proceed to FILL_HDR.
- reset asserted mid-DATA: all outputs 0 asynchronously, busy=0, no fill_done; a new fill_start restarts at adr 1, index 0.
